byte_data_memory: RTL and testbench

Parametrised, byte-addressed, big-endian data memory with a registered request/response interface, byte and halfword accesses, and hardware splitting of misaligned halfword accesses. It replaces the fixed 256-byte combinational-read data memory in the single-cycle CPU datapath with a sized, synchronous block. The load/store path and the future multi-cycle core use it; the ALU supplies the address and the register file supplies the write data.

---
 rtl/byte_data_memory.sv | 155 +++++++++++++++
 tb/tb_byte_data_memory.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// ============================================================================
// Module   : byte_data_memory
// Brief    : Byte-addressed big-endian 16-bit-word data memory with registered
//            request/response and hardware splitting of misaligned halfwords.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_data_memory #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_misaligned
);

    localparam int DEPTH = 2 ** (ADDR_W - 1);
    localparam int IDX_W = ADDR_W - 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    logic [15:0] mem_q [DEPTH];

    state_t           state_q,       state_d;
    logic             split_we_q,    split_we_d;
    logic [IDX_W-1:0] split_idx_q,   split_idx_d;
    logic [7:0]       split_wbyte_q, split_wbyte_d;
    logic [7:0]       split_rbyte_q, split_rbyte_d;
    logic             rsp_valid_q,   rsp_valid_d;
    logic [15:0]      rsp_rdata_q,   rsp_rdata_d;
    logic             rsp_mis_q,     rsp_mis_d;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [15:0]      w_rword;
    logic             w_we_hi;
    logic             w_we_lo;
    logic [7:0]       w_wbyte_hi;
    logic [7:0]       w_wbyte_lo;

    assign req_ready      = (state_q == ST_IDLE) && !rst;
    assign w_accept       = req_valid && req_ready;
    assign w_rword        = mem_q[w_idx];
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;

    always_comb begin
        state_d       = state_q;
        split_we_d    = split_we_q;
        split_idx_d   = split_idx_q;
        split_wbyte_d = split_wbyte_q;
        split_rbyte_d = split_rbyte_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_mis_d     = rsp_mis_q;
        w_idx         = req_addr[ADDR_W-1:1];
        w_we_hi       = 1'b0;
        w_we_lo       = 1'b0;
        w_wbyte_hi    = req_wdata[15:8];
        w_wbyte_lo    = req_wdata[7:0];

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_size && req_addr[0]) begin
                        // First half: byte[a] lives in the low lane of word a>>1.
                        w_we_lo       = req_we;
                        w_wbyte_lo    = req_wdata[15:8];
                        split_we_d    = req_we;
                        split_idx_d   = req_addr[ADDR_W-1:1] + (IDX_W)'(1);
                        split_wbyte_d = req_wdata[7:0];
                        split_rbyte_d = w_rword[7:0];
                        state_d       = ST_SPLIT;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b0;
                        if (req_we) begin
                            rsp_rdata_d = 16'h0000;
                            if (req_size) begin
                                w_we_hi = 1'b1;
                                w_we_lo = 1'b1;
                            end else if (req_addr[0]) begin
                                w_we_lo = 1'b1;
                            end else begin
                                w_we_hi    = 1'b1;
                                w_wbyte_hi = req_wdata[7:0];
                            end
                        end else if (req_size) begin
                            rsp_rdata_d = w_rword;
                        end else if (req_addr[0]) begin
                            rsp_rdata_d = {8'h00, w_rword[7:0]};
                        end else begin
                            rsp_rdata_d = {8'h00, w_rword[15:8]};
                        end
                    end
                end
            end
            ST_SPLIT: begin
                w_idx       = split_idx_q;
                w_we_hi     = split_we_q;
                w_wbyte_hi  = split_wbyte_q;
                rsp_valid_d = 1'b1;
                rsp_mis_d   = 1'b1;
                rsp_rdata_d = split_we_q ? 16'h0000 : {split_rbyte_q, w_rword[15:8]};
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            split_we_q    <= 1'b0;
            split_idx_q   <= '0;
            split_wbyte_q <= 8'h00;
            split_rbyte_q <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 16'h0000;
            rsp_mis_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            split_we_q    <= split_we_d;
            split_idx_q   <= split_idx_d;
            split_wbyte_q <= split_wbyte_d;
            split_rbyte_q <= split_rbyte_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_mis_q     <= rsp_mis_d;
        end
    end

    // Storage is never cleared; reset only blocks commits (e.g. the second half of a split).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_we_hi) mem_q[w_idx][15:8] <= w_wbyte_hi;
            if (w_we_lo) mem_q[w_idx][7:0]  <= w_wbyte_lo;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_byte_data_memory.sv
// ============================================================================
// Module   : tb_byte_data_memory
// Brief    : Self-checking bench for byte_data_memory (vector table, directed
//            corner sequences, randomized traffic against a byte-array model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_data_memory;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_size;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_misaligned;

    byte_data_memory #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic        sz;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] model_mem [256];
    int         n_vec;
    int         n_err;

    function automatic void check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Byte-array view of memory: a halfword is byte[a] then byte[a+1] with 8-bit wrap.
    function automatic void model_access(input logic we, input logic sz, input logic [7:0] a,
                                         input logic [15:0] wd, output logic [15:0] rd,
                                         output logic mis);
        logic [7:0] a1;
        a1  = a + 8'd1;
        mis = sz & a[0];
        rd  = 16'h0000;
        if (we) begin
            if (sz) begin
                model_mem[a]  = wd[15:8];
                model_mem[a1] = wd[7:0];
            end else begin
                model_mem[a] = wd[7:0];
            end
        end else begin
            rd = sz ? {model_mem[a], model_mem[a1]} : {8'h00, model_mem[a]};
        end
    endfunction

    function automatic void add(input logic we, input logic sz, input logic [7:0] a,
                                input logic [15:0] wd, input logic [15:0] er, input logic em);
        vec_t v;
        v.we = we; v.sz = sz; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_mis = em;
        tbl.push_back(v);
    endfunction

    task automatic xact(input logic we, input logic sz, input logic [7:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output logic mis, output int lat, output logic rdy1);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        rdy1 = req_ready;
        lat  = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rd  = rsp_rdata;
        mis = rsp_misaligned;
    endtask

    task automatic run_check(input string name, input logic we, input logic sz, input logic [7:0] a,
                             input logic [15:0] wd, input logic [15:0] er, input logic em);
        logic [15:0] rd;
        logic        mis;
        logic        rdy1;
        int          lat;
        xact(we, sz, a, wd, rd, mis, lat, rdy1);
        check({name, "_rdata"}, rd, er);
        check({name, "_mis"}, {15'd0, mis}, {15'd0, em});
        check({name, "_latency"}, 16'(lat), em ? 16'd2 : 16'd1);
        check({name, "_ready_next"}, {15'd0, rdy1}, {15'd0, !em});
    endtask

    task automatic model_check(input string name, input logic we, input logic sz,
                               input logic [7:0] a, input logic [15:0] wd);
        logic [15:0] er;
        logic        em;
        model_access(we, sz, a, wd, er, em);
        run_check(name, we, sz, a, wd, er, em);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] er;
        logic        em;
        logic [15:0] e [4];
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
        req_addr = 8'h00; req_wdata = 16'h0000;

        repeat (2) @(negedge clk);
        check("reset_ready", {15'd0, req_ready}, 16'd0);
        check("reset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("reset_rdata", rsp_rdata, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {15'd0, req_ready}, 16'd1);

        // Give every byte a known value so any later read has a defined expectation.
        for (int w = 0; w < 128; w++)
            model_check("fill", 1'b1, 1'b1, 8'(2 * w), 16'($urandom));

        // Vector table: expected values worked out by hand.
        add(1, 1, 8'h10, 16'h1234, 16'h0000, 0);
        add(0, 1, 8'h10, 16'h0000, 16'h1234, 0);
        add(0, 0, 8'h11, 16'h0000, 16'h0034, 0);
        add(1, 0, 8'h10, 16'h00AA, 16'h0000, 0);
        add(0, 1, 8'h10, 16'h0000, 16'hAA34, 0);
        add(1, 0, 8'h20, 16'h0000, 16'h0000, 0);
        add(1, 0, 8'h21, 16'h0011, 16'h0000, 0);
        add(1, 0, 8'h22, 16'h0022, 16'h0000, 0);
        add(1, 0, 8'h23, 16'h0033, 16'h0000, 0);
        add(1, 1, 8'h21, 16'hABCD, 16'h0000, 1);
        add(0, 0, 8'h20, 16'h0000, 16'h0000, 0);
        add(0, 0, 8'h21, 16'h0000, 16'h00AB, 0);
        add(0, 0, 8'h22, 16'h0000, 16'h00CD, 0);
        add(0, 0, 8'h23, 16'h0000, 16'h0033, 0);
        add(1, 1, 8'hFF, 16'hBEEF, 16'h0000, 1);
        add(0, 0, 8'hFF, 16'h0000, 16'h00BE, 0);
        add(0, 0, 8'h00, 16'h0000, 16'h00EF, 0);
        add(0, 1, 8'hFF, 16'h0000, 16'hBEEF, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            model_access(tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, er, em);
            run_check($sformatf("tbl%0d", i), tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd,
                      tbl[i].exp_rd, tbl[i].exp_mis);
        end
        @(negedge clk);
        check("hold_valid", {15'd0, rsp_valid}, 16'd0);
        check("hold_rdata", rsp_rdata, 16'hBEEF);
        check("hold_mis", {15'd0, rsp_misaligned}, 16'd1);

        // Four aligned reads back-to-back.
        for (int i = 0; i < 4; i++) e[i] = {model_mem[8'(8'h30 + 2 * i)], model_mem[8'(8'h31 + 2 * i)]};
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                check("b2b_valid", {15'd0, rsp_valid}, 16'd1);
                check("b2b_rdata", rsp_rdata, e[i-1]);
            end
            if (i < 4) begin
                req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_addr = 8'(8'h30 + 2 * i);
                @(negedge clk);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_valid", {15'd0, rsp_valid}, 16'd0);

        // Reset while the second half of a misaligned write is pending.
        req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_addr = 8'h41; req_wdata = 16'h5566;
        @(negedge clk);
        req_valid = 1'b0;
        check("split_ready_low", {15'd0, req_ready}, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        check("split_rst_no_rsp", {15'd0, rsp_valid}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("split_rst_no_rsp2", {15'd0, rsp_valid}, 16'd0);
        check("split_rst_ready", {15'd0, req_ready}, 16'd1);
        model_mem[8'h41] = 8'h55;
        model_check("split_rst_b41", 1'b0, 1'b0, 8'h41, 16'h0000);
        model_check("split_rst_b42", 1'b0, 1'b0, 8'h42, 16'h0000);

        // Reset with a write request pending: reset wins and outputs clear.
        model_check("pre_rst_read", 1'b0, 1'b1, 8'h10, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_addr = 8'h50; req_wdata = 16'h7777;
        @(negedge clk);
        check("rst_req_ready0", {15'd0, req_ready}, 16'd0);
        @(negedge clk);
        check("rst_req_ready1", {15'd0, req_ready}, 16'd0);
        check("rst_req_valid", {15'd0, rsp_valid}, 16'd0);
        check("rst_req_rdata", rsp_rdata, 16'h0000);
        check("rst_req_mis", {15'd0, rsp_misaligned}, 16'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_req_ready_after", {15'd0, req_ready}, 16'd1);
        check("rst_req_no_rsp", {15'd0, rsp_valid}, 16'd0);
        model_check("rst_req_mem", 1'b0, 1'b1, 8'h50, 16'h0000);

        // Randomized mix against the byte-array model.
        for (int i = 0; i < 300; i++)
            model_check("rand", 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
